// File: rtl/ov7670_capture_param.sv
// OV7670 capture stage: pairs RGB565 bytes into pixels, decimates in H and V,
// and writes RGB444 or 8-bit luma to a linear frame-buffer address.
module ov7670_capture_param #(
  parameter int ADDR_W   = 17,
  parameter int MAX_ADDR = 76799,
  parameter int H_DECIM  = 4,
  parameter int V_DECIM  = 4
) (
  input  logic              pclk,
  input  logic              reset_n,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        d,
  input  logic              mode,
  output logic [ADDR_W-1:0] addr,
  output logic [11:0]       dout,
  output logic              we,
  output logic              frame_done,
  output logic [7:0]        frame_count,
  output logic              overflow
);

  localparam logic [2:0]        H_LAST = 3'(H_DECIM - 1);
  localparam logic [2:0]        V_LAST = 3'(V_DECIM - 1);
  localparam logic [ADDR_W-1:0] MAX_A  = ADDR_W'(MAX_ADDR);

  logic              vsync_s_q, href_s_q;
  logic [7:0]        d_s_q;

  logic              vsync_prev_q, vsync_prev_d;
  logic              href_prev_q, href_prev_d;
  logic              armed_q, armed_d;
  logic              first_line_q, first_line_d;
  logic              line_active_q, line_active_d;
  logic              phase_q, phase_d;
  logic              mode_q, mode_d;
  logic [7:0]        hi_q, hi_d;
  logic [2:0]        h_cnt_q, h_cnt_d;
  logic [2:0]        v_cnt_q, v_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [11:0]       dout_q, dout_d;
  logic              we_q, we_d;
  logic              frame_done_q, frame_done_d;
  logic [7:0]        frame_count_q, frame_count_d;
  logic              overflow_q, overflow_d;
  logic              wrote_q, wrote_d;

  logic [15:0]       pix;
  logic [4:0]        r5, b5;
  logic [5:0]        g6;
  logic [7:0]        r8, g8, b8, luma;
  logic [10:0]       luma_sum;
  logic [11:0]       rgb444;
  logic              vsync_rise, line_start;

  // Camera drives data on the rising edge, so sample mid-cycle.
  always_ff @(negedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_s_q <= 1'b0;
      href_s_q  <= 1'b0;
      d_s_q     <= 8'd0;
    end else begin
      vsync_s_q <= vsync;
      href_s_q  <= href;
      d_s_q     <= d;
    end
  end

  always_comb begin
    pix      = {hi_q, d_s_q};
    r5       = pix[15:11];
    g6       = pix[10:5];
    b5       = pix[4:0];
    r8       = {r5, r5[4:2]};
    g8       = {g6, g6[5:4]};
    b8       = {b5, b5[4:2]};
    luma_sum = 11'({r8, 1'b0}) + 11'(g8) * 11'd5 + 11'(b8);
    luma     = 8'(luma_sum >> 3);
    rgb444   = {r5[4:1], g6[5:2], b5[4:1]};
  end

  always_comb begin
    vsync_rise    = vsync_s_q & ~vsync_prev_q;
    line_start    = href_s_q & ~href_prev_q;
    vsync_prev_d  = vsync_s_q;
    href_prev_d   = href_s_q;
    armed_d       = armed_q;
    first_line_d  = first_line_q;
    line_active_d = line_active_q;
    phase_d       = phase_q;
    mode_d        = mode_q;
    hi_d          = hi_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    addr_d        = we_q ? addr_q + ADDR_W'(1) : addr_q;
    dout_d        = dout_q;
    we_d          = 1'b0;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    overflow_d    = overflow_q;
    wrote_d       = wrote_q;

    if (vsync_s_q) begin
      // Vertical blanking: abort any line, rewind, and close out the frame.
      armed_d       = 1'b1;
      first_line_d  = 1'b1;
      line_active_d = 1'b0;
      phase_d       = 1'b0;
      h_cnt_d       = 3'd0;
      v_cnt_d       = 3'd0;
      addr_d        = '0;
      mode_d        = mode;
      if (vsync_rise) begin
        overflow_d = 1'b0;
        wrote_d    = 1'b0;
        if (wrote_q) begin
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + 8'd1;
        end
      end
    end else if (line_start) begin
      line_active_d = 1'b1;
      phase_d       = 1'b1;
      hi_d          = d_s_q;
      h_cnt_d       = 3'd0;
      if (first_line_q) begin
        first_line_d = 1'b0;
        v_cnt_d      = 3'd0;
      end else begin
        v_cnt_d = (v_cnt_q == V_LAST) ? 3'd0 : v_cnt_q + 3'd1;
      end
    end else if (line_active_q && href_s_q) begin
      if (!phase_q) begin
        hi_d    = d_s_q;
        phase_d = 1'b1;
      end else begin
        phase_d = 1'b0;
        h_cnt_d = (h_cnt_q == H_LAST) ? 3'd0 : h_cnt_q + 3'd1;
        if (armed_q && h_cnt_q == 3'd0 && v_cnt_q == 3'd0) begin
          if (addr_q > MAX_A) begin
            overflow_d = 1'b1;
          end else begin
            we_d    = 1'b1;
            wrote_d = 1'b1;
            dout_d  = mode_q ? {4'b0, luma} : rgb444;
          end
        end
      end
    end else begin
      line_active_d = 1'b0;
      phase_d       = 1'b0;
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_prev_q  <= 1'b0;
      href_prev_q   <= 1'b0;
      armed_q       <= 1'b0;
      first_line_q  <= 1'b1;
      line_active_q <= 1'b0;
      phase_q       <= 1'b0;
      mode_q        <= 1'b0;
      hi_q          <= 8'd0;
      h_cnt_q       <= 3'd0;
      v_cnt_q       <= 3'd0;
      addr_q        <= '0;
      dout_q        <= 12'd0;
      we_q          <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= 8'd0;
      overflow_q    <= 1'b0;
      wrote_q       <= 1'b0;
    end else begin
      vsync_prev_q  <= vsync_prev_d;
      href_prev_q   <= href_prev_d;
      armed_q       <= armed_d;
      first_line_q  <= first_line_d;
      line_active_q <= line_active_d;
      phase_q       <= phase_d;
      mode_q        <= mode_d;
      hi_q          <= hi_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      addr_q        <= addr_d;
      dout_q        <= dout_d;
      we_q          <= we_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      overflow_q    <= overflow_d;
      wrote_q       <= wrote_d;
    end
  end

  assign addr        = addr_q;
  assign dout        = dout_q;
  assign we          = we_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_ov7670_capture_param.sv
// Randomized bench for ov7670_capture_param: a frame/line level model predicts
// every write, the frame status and the reset behaviour.
module tb_ov7670_capture_param;

  localparam int ADDR_W   = 8;
  localparam int MAX_ADDR = 9;
  localparam int H_DECIM  = 3;
  localparam int V_DECIM  = 2;

  logic              pclk = 1'b0;
  logic              reset_n, vsync, href, mode;
  logic [7:0]        d;
  logic [ADDR_W-1:0] addr;
  logic [11:0]       dout;
  logic              we, frame_done, overflow;
  logic [7:0]        frame_count;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t expq[$];
  wr_t mon_w;
  int  line_pix[$];
  int  checks = 0;
  int  errors = 0;
  int  m_addr, m_writes, m_line, m_count;
  bit  m_ovf, m_armed, m_mode;

  ov7670_capture_param #(
    .ADDR_W(ADDR_W), .MAX_ADDR(MAX_ADDR), .H_DECIM(H_DECIM), .V_DECIM(V_DECIM)
  ) dut (
    .pclk(pclk), .reset_n(reset_n), .vsync(vsync), .href(href), .d(d),
    .mode(mode), .addr(addr), .dout(dout), .we(we), .frame_done(frame_done),
    .frame_count(frame_count), .overflow(overflow)
  );

  always #5 pclk = ~pclk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Expected write data straight from the colour-format rules.
  function automatic int exp_data(input int p, input bit m);
    int r5, g6, b5, r8, g8, b8;
    r5 = (p >> 11) & 31;
    g6 = (p >> 5) & 63;
    b5 = p & 31;
    if (!m) return ((r5 >> 1) << 8) | ((g6 >> 2) << 4) | (b5 >> 1);
    r8 = (r5 << 3) | (r5 >> 2);
    g8 = (g6 << 2) | (g6 >> 4);
    b8 = (b5 << 3) | (b5 >> 2);
    return (2 * r8 + 5 * g8 + b8) / 8;
  endfunction

  task automatic drive_cycle(input bit v, input bit h, input logic [7:0] b);
    @(posedge pclk);
    #1;
    vsync = v;
    href  = h;
    d     = b;
  endtask

  task automatic send_line(input bit odd_byte, input bit no_idle);
    for (int i = 0; i < line_pix.size(); i++) begin
      drive_cycle(1'b0, 1'b1, 8'(line_pix[i] >> 8));
      drive_cycle(1'b0, 1'b1, 8'(line_pix[i]));
      if (m_armed && (m_line % V_DECIM == 0) && (i % H_DECIM == 0)) begin
        if (m_addr <= MAX_ADDR) begin
          expq.push_back('{addr: m_addr, data: exp_data(line_pix[i], m_mode)});
          m_addr++;
          m_writes++;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    if (odd_byte) drive_cycle(1'b0, 1'b1, 8'($urandom));
    m_line++;
    mode = 1'($urandom);
    if (!no_idle)
      for (int k = 0; k < 3; k++) drive_cycle(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic start_frame(input bit keep_href, input bit new_mode);
    drive_cycle(1'b1, keep_href, 8'($urandom));
    mode = new_mode;
    @(negedge pclk);
    checkOutput("overflow_sticky", int'(overflow), int'(m_ovf));
    @(negedge pclk);
    if (m_writes > 0) m_count = (m_count + 1) % 256;
    checkOutput("frame_done", int'(frame_done), int'(m_writes > 0));
    checkOutput("frame_count", int'(frame_count), m_count);
    checkOutput("overflow_clear", int'(overflow), 0);
    checkOutput("addr_clear", int'(addr), 0);
    checkOutput("writes_left", expq.size(), 0);
    @(negedge pclk);
    checkOutput("frame_done_pulse", int'(frame_done), 0);
    drive_cycle(1'b1, 1'b0, 8'($urandom));
    drive_cycle(1'b0, 1'b0, 8'($urandom));
    drive_cycle(1'b0, 1'b0, 8'($urandom));
    expq.delete();
    m_addr   = 0;
    m_writes = 0;
    m_line   = 0;
    m_ovf    = 1'b0;
    m_armed  = 1'b1;
    m_mode   = new_mode;
  endtask

  task automatic random_line(input int max_pix);
    int n;
    line_pix.delete();
    n = $urandom_range(max_pix, 0);
    for (int i = 0; i < n; i++) line_pix.push_back(int'($urandom_range(16'hFFFF, 0)));
  endtask

  // Scoreboard: every write pulse must match the next predicted write.
  always @(negedge pclk) begin
    if (reset_n && we) begin
      if (expq.size() == 0) begin
        checkOutput("spurious_we", 1, 0);
      end else begin
        mon_w = expq.pop_front();
        checkOutput("wr_addr", int'(addr), mon_w.addr);
        checkOutput("wr_data", int'(dout), mon_w.data);
      end
    end
  end

  task automatic applyStimulus();
    bit odd, abort;
    int nlines;

    start_frame(1'b0, 1'b0);

    line_pix = {};
    line_pix.push_back('hF800); line_pix.push_back('h1234);
    line_pix.push_back('h5678); line_pix.push_back('h07E0);
    send_line(1'b0, 1'b0);
    random_line(6); line_pix.push_back('h4321); send_line(1'b0, 1'b0);
    random_line(6); line_pix.push_back('hABCD); send_line(1'b1, 1'b0);
    start_frame(1'b0, 1'b1);

    line_pix = {};
    line_pix.push_back('hFFFF); line_pix.push_back('h0001); line_pix.push_back('h0002);
    line_pix.push_back('h0000); line_pix.push_back('h0003); line_pix.push_back('h0004);
    line_pix.push_back('hF800);
    send_line(1'b1, 1'b0);
    start_frame(1'b0, 1'b0);

    for (int l = 0; l < 5; l++) begin
      line_pix.delete();
      for (int i = 0; i < 12; i++) line_pix.push_back(int'($urandom_range(16'hFFFF, 0)));
      send_line(1'b0, 1'b0);
    end
    start_frame(1'b0, 1'($urandom));

    for (int f = 0; f < 20; f++) begin
      nlines = $urandom_range(6, 1);
      abort  = 1'($urandom);
      for (int l = 0; l < nlines; l++) begin
        random_line(10);
        odd = 1'($urandom);
        if (line_pix.size() == 0) odd = 1'b1;
        send_line(odd, abort && (l == nlines - 1));
      end
      start_frame(abort, 1'($urandom));
    end

    random_line(6);
    line_pix.push_back('h7BEF);
    send_line(1'b0, 1'b0);
    drive_cycle(1'b0, 1'b1, 8'hA5);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("rst_addr", int'(addr), 0);
    checkOutput("rst_dout", int'(dout), 0);
    checkOutput("rst_we", int'(we), 0);
    checkOutput("rst_frame_done", int'(frame_done), 0);
    checkOutput("rst_frame_count", int'(frame_count), 0);
    checkOutput("rst_overflow", int'(overflow), 0);
    expq.delete();
    m_armed  = 1'b0;
    m_count  = 0;
    m_writes = 0;
    m_ovf    = 1'b0;
    m_line   = 0;
    @(negedge pclk);
    #2;
    reset_n = 1'b1;
    drive_cycle(1'b0, 1'b0, 8'h00);
    for (int l = 0; l < 3; l++) begin
      random_line(8);
      line_pix.push_back('h1F1F);
      send_line(1'b0, 1'b0);
    end
    start_frame(1'b0, 1'b0);
    for (int l = 0; l < 3; l++) begin
      random_line(8);
      line_pix.push_back('h0F0F);
      send_line(1'b0, 1'b0);
    end
    start_frame(1'b0, 1'b1);
  endtask

  initial begin
    reset_n  = 1'b1;
    vsync    = 1'b0;
    href     = 1'b0;
    d        = 8'd0;
    mode     = 1'b0;
    m_addr   = 0;
    m_writes = 0;
    m_line   = 0;
    m_count  = 0;
    m_ovf    = 1'b0;
    m_armed  = 1'b0;
    m_mode   = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("init_addr", int'(addr), 0);
    checkOutput("init_we", int'(we), 0);
    checkOutput("init_frame_count", int'(frame_count), 0);
    checkOutput("init_overflow", int'(overflow), 0);
    #20;
    @(negedge pclk);
    #2;
    reset_n = 1'b1;
    applyStimulus();
    repeat (4) @(posedge pclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
